// File: rtl/clock_mode_ctrl_pkg.sv
// clock_pkg: shared types and constants for the HH:MM clock mode controller.
//   mode_e         : controller state encoding, also exported on the mode port
//   HOUR_W/MIN_W/SEC_W/LED_W : datapath widths
//   MAX_HOUR/MAX_MIN         : wrap points for the edit increment
//   ALARM_RST_HOUR           : alarm hour after reset (alarm minute resets to 0)
//   inc_hour/inc_min         : wrapping increment helpers
package clock_pkg;

    localparam int unsigned HOUR_W         = 5;
    localparam int unsigned MIN_W          = 6;
    localparam int unsigned SEC_W          = 6;
    localparam int unsigned LED_W          = 6;
    localparam int unsigned MAX_HOUR       = 23;
    localparam int unsigned MAX_MIN        = 59;
    localparam int unsigned ALARM_RST_HOUR = 7;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        T_HOUR = 3'd1,
        T_MIN  = 3'd2,
        A_HOUR = 3'd3,
        A_MIN  = 3'd4
    } mode_e;

    function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] h);
        return (h >= HOUR_W'(MAX_HOUR)) ? '0 : h + 1'b1;
    endfunction

    function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] m);
        return (m >= MIN_W'(MAX_MIN)) ? '0 : m + 1'b1;
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// clock_mode_ctrl_if: board/datapath-facing signal bundle of the mode controller.
//   master modport: the surrounding clock top (drives tick, raw buttons, current time;
//                   receives load strobe, edit values, alarm, display/blink controls, LEDs)
//   slave modport : clock_mode_ctrl itself
interface clock_mode_ctrl_if;
    import clock_pkg::*;

    logic              tick_1hz;
    logic              btn_mode;
    logic              btn_inc;
    logic [HOUR_W-1:0] cur_hour;
    logic [MIN_W-1:0]  cur_min;
    logic [SEC_W-1:0]  cur_sec;

    logic              set_load;
    logic [HOUR_W-1:0] set_hour;
    logic [MIN_W-1:0]  set_min;
    logic [HOUR_W-1:0] alarm_hour;
    logic [MIN_W-1:0]  alarm_min;
    logic              disp_alarm;
    logic              blink_hour;
    logic              blink_min;
    mode_e             mode;
    logic [LED_W-1:0]  alarm_leds;

    modport master (
        output tick_1hz, btn_mode, btn_inc, cur_hour, cur_min, cur_sec,
        input  set_load, set_hour, set_min, alarm_hour, alarm_min,
               disp_alarm, blink_hour, blink_min, mode, alarm_leds
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, cur_hour, cur_min, cur_sec,
        output set_load, set_hour, set_min, alarm_hour, alarm_min,
               disp_alarm, blink_hour, blink_min, mode, alarm_leds
    );

endinterface

// File: rtl/clock_mode_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stable-count debounce and rising-edge press pulse.
//   clk, rst : system clock, synchronous active-high reset
//   btn_i    : raw asynchronous button level (active-high)
//   press_o  : one-cycle pulse when the debounced level rises; no repeat while held
// The debounced level only follows the synchronised input after it has differed
// from it for DEBOUNCE_CYC consecutive cycles.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             meta_q, sync_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any cycle where the input agrees with the accepted level restarts the count.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level_d = sync_q;
                press_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: mode/time-set/alarm controller for the HH:MM clock.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : clock_mode_ctrl_if.slave
//              in : tick_1hz, btn_mode, btn_inc, cur_hour, cur_min, cur_sec
//              out: set_load, set_hour, set_min, alarm_hour, alarm_min,
//                   disp_alarm, blink_hour, blink_min, mode, alarm_leds
// Sequence RUN -> T_HOUR -> T_MIN (load time) -> A_HOUR -> A_MIN (store alarm) -> RUN.
// Edit states abort to RUN after TIMEOUT_S idle seconds. The alarm rings for RING_S
// seconds with a rotating LED, and any press stops it without changing mode.
// Optional feature macro CLOCK_SNOOZE_EN: inc while ringing snoozes for SNOOZE_MIN
// minutes, mode while ringing stops and cancels the snooze.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 50_000,
    parameter int unsigned TIMEOUT_S    = 30,
    parameter int unsigned RING_S       = 60,
    parameter int unsigned SNOOZE_MIN   = 5
) (
    input  logic               clk,
    input  logic               rst,
    clock_mode_ctrl_if.slave   bus
);

    localparam int unsigned TO_W = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
    localparam int unsigned RC_W = (RING_S > 1) ? $clog2(RING_S) : 1;

    mode_e             state_q, state_d;
    logic              mode_p, inc_p, any_p;
    logic              edit_st, adv, timeout_hit, trigger, snooze_fire;
    logic [HOUR_W-1:0] edit_hour_q, edit_hour_d, alarm_hour_q, alarm_hour_d;
    logic [MIN_W-1:0]  edit_min_q, edit_min_d, alarm_min_q, alarm_min_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              blink_q, blink_d;
    logic              ringing_q, ringing_d;
    logic [RC_W-1:0]   ring_cnt_q, ring_cnt_d;
    logic [LED_W-1:0]  leds_q, leds_d;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
        .clk(clk), .rst(rst), .btn_i(bus.btn_mode), .press_o(mode_p)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
        .clk(clk), .rst(rst), .btn_i(bus.btn_inc), .press_o(inc_p)
    );

    assign any_p   = mode_p | inc_p;
    assign edit_st = (state_q != RUN);
    // A press while ringing only stops the ring, so it never advances the FSM.
    assign adv     = mode_p & ~ringing_q;
    assign timeout_hit = edit_st & bus.tick_1hz & ~any_p &
                         (to_cnt_q == TO_W'(TIMEOUT_S - 1));
    // A mode press in the trigger cycle leaves RUN, so that trigger is dropped.
    assign trigger = (state_q == RUN) & ~ringing_q & ~mode_p & bus.tick_1hz &
                     (bus.cur_hour == alarm_hour_q) & (bus.cur_min == alarm_min_q) &
                     (bus.cur_sec == '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (adv) begin
            unique case (state_q)
                RUN:     state_d = T_HOUR;
                T_HOUR:  state_d = T_MIN;
                T_MIN:   state_d = A_HOUR;
                A_HOUR:  state_d = A_MIN;
                default: state_d = RUN;
            endcase
        end else if (timeout_hit) begin
            state_d = RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.set_load   = adv & (state_q == T_MIN);
        bus.disp_alarm = edit_st;
        bus.blink_hour = blink_q & ((state_q == T_HOUR) | (state_q == A_HOUR));
        bus.blink_min  = blink_q & ((state_q == T_MIN)  | (state_q == A_MIN));
    end

    assign bus.mode       = state_q;
    assign bus.set_hour   = edit_hour_q;
    assign bus.set_min    = edit_min_q;
    assign bus.alarm_hour = alarm_hour_q;
    assign bus.alarm_min  = alarm_min_q;
    assign bus.alarm_leds = leds_q;

    // ---------------- edit / alarm registers, timeout, blink ----------------
    always_comb begin
        edit_hour_d  = edit_hour_q;
        edit_min_d   = edit_min_q;
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        to_cnt_d     = to_cnt_q;
        blink_d      = blink_q;

        if (adv && state_q == RUN) begin
            edit_hour_d = bus.cur_hour;
            edit_min_d  = bus.cur_min;
        end else if (adv && state_q == T_MIN) begin
            edit_hour_d = alarm_hour_q;
            edit_min_d  = alarm_min_q;
        end else if (adv && state_q == A_MIN) begin
            alarm_hour_d = edit_hour_q;
            alarm_min_d  = edit_min_q;
        end else if (inc_p && !mode_p) begin
            unique case (state_q)
                T_HOUR, A_HOUR: edit_hour_d = inc_hour(edit_hour_q);
                T_MIN, A_MIN:   edit_min_d  = inc_min(edit_min_q);
                default: ;
            endcase
        end

        if (!edit_st || any_p || state_d != state_q) to_cnt_d = '0;
        else if (bus.tick_1hz)                       to_cnt_d = to_cnt_q + 1'b1;

        if (!edit_st)          blink_d = 1'b0;
        else if (bus.tick_1hz) blink_d = ~blink_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edit_hour_q  <= '0;
            edit_min_q   <= '0;
            alarm_hour_q <= HOUR_W'(ALARM_RST_HOUR);
            alarm_min_q  <= '0;
            to_cnt_q     <= '0;
            blink_q      <= 1'b0;
        end else begin
            edit_hour_q  <= edit_hour_d;
            edit_min_q   <= edit_min_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            to_cnt_q     <= to_cnt_d;
            blink_q      <= blink_d;
        end
    end

    // ---------------- alarm ringing ----------------
    always_comb begin
        ringing_d  = ringing_q;
        ring_cnt_d = ring_cnt_q;
        leds_d     = leds_q;
        if (ringing_q) begin
            if (any_p) begin
                ringing_d = 1'b0;
                leds_d    = '0;
            end else if (bus.tick_1hz) begin
                if (ring_cnt_q == RC_W'(RING_S - 1)) begin
                    ringing_d = 1'b0;
                    leds_d    = '0;
                end else begin
                    ring_cnt_d = ring_cnt_q + 1'b1;
                    leds_d     = {leds_q[LED_W-2:0], leds_q[LED_W-1]};
                end
            end
        end else if (trigger || snooze_fire) begin
            ringing_d  = 1'b1;
            ring_cnt_d = '0;
            leds_d     = LED_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ringing_q  <= 1'b0;
            ring_cnt_q <= '0;
            leds_q     <= '0;
        end else begin
            ringing_q  <= ringing_d;
            ring_cnt_q <= ring_cnt_d;
            leds_q     <= leds_d;
        end
    end

`ifdef CLOCK_SNOOZE_EN
    localparam int unsigned SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int unsigned SNZ_W     = $clog2(SNZ_TICKS + 1);

    logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
    logic             snz_act_q, snz_act_d;

    // Restart only happens in RUN; an expiry seen in an edit state is discarded.
    assign snooze_fire = snz_act_q & bus.tick_1hz & (snz_cnt_q == SNZ_W'(1)) &
                         (state_q == RUN) & ~mode_p;

    always_comb begin
        snz_cnt_d = snz_cnt_q;
        snz_act_d = snz_act_q;
        if (ringing_q && any_p) begin
            // mode wins over a simultaneous inc, so that case cancels
            snz_act_d = inc_p & ~mode_p;
            snz_cnt_d = SNZ_W'(SNZ_TICKS);
        end else if (trigger) begin
            snz_act_d = 1'b0;
        end else if (snz_act_q && bus.tick_1hz) begin
            if (snz_cnt_q == SNZ_W'(1)) snz_act_d = 1'b0;
            else                        snz_cnt_d = snz_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snz_cnt_q <= '0;
            snz_act_q <= 1'b0;
        end else begin
            snz_cnt_q <= snz_cnt_d;
            snz_act_q <= snz_act_d;
        end
    end
`else
    assign snooze_fire = 1'b0;
`endif

endmodule
